// File: rtl/qspi_emu_pkg.sv
// qspi_emu_pkg: shared types for the QSPI/QPI memory emulator.
// Holds the command-decoder state encoding and the supported opcode values.
// No ports; imported by qspi_mem_emu.
package qspi_emu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    WAIT   = 3'd3,
    RDATA  = 3'd4,
    WDATA  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_QREAD     = 8'hEB;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_QWRITE    = 8'h38;
  localparam logic [7:0] CMD_QPI_EN    = 8'h35;
  localparam logic [7:0] CMD_QPI_EX    = 8'hF5;
  localparam logic [7:0] CMD_RST_EN    = 8'h66;
  localparam logic [7:0] CMD_RST       = 8'h99;

endpackage

// File: rtl/qspi_emu_sync.sv
// qspi_emu_sync: 2-flop synchroniser plus a third flop for edge detection.
// Latency: lvl is 2 clk behind din; rise/fall are single-clk pulses on the same cycle as lvl changes.
// No backpressure. Ports: clk, rst (sync, active-high), din (async), lvl, rise, fall.
module qspi_emu_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/qspi_mem_emu.sv
// qspi_mem_emu: multi-device SPI/QPI PSRAM/flash emulator oversampling the bus on clk.
// Latency: dio_out changes 1 clk after a synchronised SCK fall; memory read 1 clk; backdoor visible next clk.
// No backpressure: bus timing is set by the master, clk must be >= 4x SCK.
// Ports: clk/rst, ce_n/sck/dio_in (bus in), dio_out/dio_oe (bus out), bd_we/bd_addr/bd_wdata (preload),
//        qpi_mode (per-device mode), err (sticky protocol error).
module qspi_mem_emu
  import qspi_emu_pkg::*;
#(
  parameter int   NUM_CE      = 2,
  parameter int   DEPTH_BYTES = 65536,
  parameter int   ADDR_W      = 24,
  parameter int   WAIT_CYCLES = 6,
  parameter logic INIT_QPI    = 1'b0,
  localparam int  BD_W        = $clog2(NUM_CE * DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CE-1:0] ce_n,
  input  logic              sck,
  input  logic [3:0]        dio_in,
  output logic [3:0]        dio_out,
  output logic [3:0]        dio_oe,
  input  logic              bd_we,
  input  logic [BD_W-1:0]   bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic [NUM_CE-1:0] qpi_mode,
  output logic              err
);

  localparam int AW        = $clog2(DEPTH_BYTES);
  localparam int DEV_W     = (NUM_CE > 1) ? $clog2(NUM_CE) : 1;
  localparam int MEM_BYTES = NUM_CE * DEPTH_BYTES;

  // ---------------- synchronisers ----------------
  logic              sck_lvl, sck_rise, sck_fall;
  logic [NUM_CE-1:0] ce_s, ce_rise, ce_fall;

  qspi_emu_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(sck), .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
    qspi_emu_sync #(.RST_VAL(1'b1)) u_sync_ce (
      .clk(clk), .rst(rst), .din(ce_n[i]), .lvl(ce_s[i]), .rise(ce_rise[i]), .fall(ce_fall[i])
    );
  end

  // Only pulses and the CE levels are needed; SCK level and CE falls are not.
  logic unused_ok;

  // ---------------- state ----------------
  state_t              state, state_n;
  logic [DEV_W-1:0]    dev, sel;
  logic [7:0]          op, cmd_sh, cnt, wr_sh, out_sh, mem_rdata;
  logic                wide;
  logic [ADDR_W-1:0]   addr_sh;
  logic [AW-1:0]       addr;
  logic [2:0]          wr_cnt, out_cnt;
  logic [NUM_CE-1:0]   rst_en;
  logic [7:0]          mem [MEM_BYTES];

  // ---------------- decode ----------------
  int                  n_low;
  logic                go, err_set;
  logic [7:0]          cmd_full, wr_byte, rd_src, rd_rest;
  logic                cmd_last, cmd_wide, cmd_bad;
  state_t              cmd_next, addr_next;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                addr_last, is_read, wait_last, wr_last, rd_last, bus_we;
  logic [3:0]          rd_nib;
  logic [BD_W-1:0]     mem_idx;

  always_comb begin
    n_low = 0;
    sel   = '0;
    for (int i = 0; i < NUM_CE; i++) begin
      if (!ce_s[i]) begin
        n_low = n_low + 1;
        sel   = DEV_W'(i);
      end
    end
  end

  // Bus events only count while the latched device alone is selected.
  assign go = (n_low == 1) && !ce_rise[dev];

  always_comb begin
    cmd_full = qpi_mode[dev] ? {cmd_sh[3:0], dio_in} : {cmd_sh[6:0], dio_in[0]};
    cmd_last = qpi_mode[dev] ? (cnt == 8'd1) : (cnt == 8'd7);
    cmd_wide = qpi_mode[dev] || (cmd_full == CMD_QREAD) || (cmd_full == CMD_QWRITE);
    cmd_next = IGNORE;
    cmd_bad  = 1'b0;
    case (cmd_full)
      CMD_READ, CMD_WRITE: begin
        if (qpi_mode[dev]) cmd_bad = 1'b1;
        else               cmd_next = ADDR;
      end
      CMD_FAST_READ, CMD_QREAD, CMD_QWRITE: cmd_next = ADDR;
      CMD_QPI_EN, CMD_QPI_EX, CMD_RST_EN:   cmd_next = IGNORE;
      CMD_RST:  cmd_bad = !rst_en[dev];    // only valid right after 0x66
      default:  cmd_bad = 1'b1;
    endcase

    addr_nxt  = wide ? {addr_sh[ADDR_W-5:0], dio_in} : {addr_sh[ADDR_W-2:0], dio_in[0]};
    addr_last = wide ? (cnt == 8'(ADDR_W/4 - 1)) : (cnt == 8'(ADDR_W - 1));
    is_read   = (op == CMD_READ) || (op == CMD_FAST_READ) || (op == CMD_QREAD);
    addr_next = !is_read ? WDATA
              : ((op != CMD_READ) && (WAIT_CYCLES > 0)) ? WAIT : RDATA;
    wait_last = (cnt == 8'(WAIT_CYCLES - 1));

    wr_byte = wide ? {wr_sh[3:0], dio_in} : {wr_sh[6:0], dio_in[0]};
    wr_last = wide ? (wr_cnt == 3'd1) : (wr_cnt == 3'd7);

    // First bit/nibble of a byte comes straight from the prefetched read data.
    rd_src  = (out_cnt == 3'd0) ? mem_rdata : out_sh;
    rd_nib  = wide ? rd_src[7:4] : {2'b00, rd_src[7], 1'b0};
    rd_rest = wide ? {rd_src[3:0], 4'h0} : {rd_src[6:0], 1'b0};
    rd_last = wide ? (out_cnt == 3'd1) : (out_cnt == 3'd7);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    err_set = 1'b0;
    if (n_low > 1) begin
      state_n = IGNORE;
      err_set = 1'b1;
    end else begin
      case (state)
        IDLE:   if (n_low == 1) state_n = CMD;
        IGNORE: if (n_low == 0) state_n = IDLE;
        default: begin
          if (ce_rise[dev]) begin
            state_n = IDLE;
          end else if (go && sck_rise) begin
            case (state)
              CMD: if (cmd_last) begin
                state_n = cmd_next;
                err_set = cmd_bad;
              end
              ADDR: if (addr_last) state_n = addr_next;
              WAIT: if (wait_last) state_n = RDATA;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dev      <= '0;
      op       <= '0;
      wide     <= 1'b0;
      cnt      <= '0;
      cmd_sh   <= '0;
      addr_sh  <= '0;
      addr     <= '0;
      wr_sh    <= '0;
      wr_cnt   <= '0;
      out_sh   <= '0;
      out_cnt  <= '0;
      rst_en   <= '0;
      qpi_mode <= {NUM_CE{INIT_QPI}};
      err      <= 1'b0;
      dio_out  <= 4'h0;
    end else begin
      if (err_set) err <= 1'b1;
      if (state_n != RDATA) dio_out <= 4'h0;
      case (state)
        IDLE: if (state_n == CMD) begin
          dev <= sel;
          cnt <= '0;
        end
        CMD: if (go && sck_rise) begin
          cmd_sh <= cmd_full;
          cnt    <= cnt + 8'd1;
          if (cmd_last) begin
            op          <= cmd_full;
            wide        <= cmd_wide;
            cnt         <= '0;
            rst_en[dev] <= (cmd_full == CMD_RST_EN);
            if (cmd_full == CMD_QPI_EN) qpi_mode[dev] <= 1'b1;
            if ((cmd_full == CMD_QPI_EX) || ((cmd_full == CMD_RST) && rst_en[dev]))
              qpi_mode[dev] <= 1'b0;
          end
        end
        ADDR: if (go && sck_rise) begin
          addr_sh <= addr_nxt;
          cnt     <= cnt + 8'd1;
          if (addr_last) begin
            addr    <= addr_nxt[AW-1:0];    // address taken modulo device depth
            cnt     <= '0;
            wr_cnt  <= '0;
            out_cnt <= '0;
          end
        end
        WAIT: if (go && sck_rise) cnt <= cnt + 8'd1;
        RDATA: if (go && sck_fall) begin
          dio_out <= rd_nib;
          out_sh  <= rd_rest;
          if (rd_last) begin
            addr    <= addr + AW'(1);     // prefetch next byte during the last bit
            out_cnt <= '0;
          end else begin
            out_cnt <= out_cnt + 3'd1;
          end
        end
        WDATA: if (go && sck_rise) begin
          wr_sh <= wr_byte;
          if (wr_last) begin
            addr   <= addr + AW'(1);
            wr_cnt <= '0;
          end else begin
            wr_cnt <= wr_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_idx = BD_W'({dev, addr});
  assign bus_we  = go && sck_rise && (state == WDATA) && wr_last;

  // Bus write is issued after the backdoor write so it wins on a collision.
  always_ff @(posedge clk) begin
    if (bd_we)  mem[bd_addr] <= bd_wdata;
    if (bus_we) mem[mem_idx] <= wr_byte;
    mem_rdata <= mem[mem_idx];
  end

  assign dio_oe = ((state == RDATA) && go) ? (wide ? 4'hF : 4'b0010) : 4'h0;

  assign unused_ok = ^{sck_lvl, ce_fall, cmd_sh[7], wr_sh[7], addr_sh[ADDR_W-1]};

endmodule
